// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell with a registered borrow, LSB first.
// Optional SERIAL_SUB_ADD_MODE_EN adds a 'sub' input; when it is low the same cell adds instead.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             br_next;
    logic             d;
    logic             last_bit;
`ifdef SERIAL_SUB_ADD_MODE_EN
    logic             sub_r;
`endif

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Single bit cell: the sum bit is the same for add and subtract, only the carry/borrow differs.
    always_comb begin
        d        = a_sh[0] ^ b_sh[0] ^ br;
`ifdef SERIAL_SUB_ADD_MODE_EN
        if (sub_r) begin
            br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        end else begin
            br_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & br) | (b_sh[0] & br);
        end
`else
        br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
`endif
        res_next = {d, res_sh[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
            sub_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        res_sh <= '0;
                        cnt    <= '0;
                        br     <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
                        sub_r  <= sub;
`endif
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    br     <= br_next;
                    // The counter stops at WIDTH-1 so it never wraps for power-of-two widths.
                    if (last_bit) begin
                        diff   <= res_next;
                        borrow <= br_next;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready = (state == IDLE);
    assign busy  = (state == SHIFT);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): expected results queued at acceptance, checked on done.
// Define SERIAL_SUB_ADD_MODE_EN to also exercise the add mode.
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] diff;
        logic         br;
        int           cyc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;

    exp_t q[$];
    int   cyc;
    int   compared;
    int   mismatched;
    logic pend_ready;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
`ifdef SERIAL_SUB_ADD_MODE_EN
        .sub    (sub),
`endif
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one request; push the model's result only when the operation should complete.
    task automatic applyStimulus(input logic [W-1:0] va, input logic [W-1:0] vb,
                                 input logic vsub, input bit expect_result);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_before_start", 32'(ready), 32'd1);
        a     = va;
        b     = vb;
        sub   = vsub;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        sub   = ~vsub;
        checkOutput("busy_after_accept", 32'(busy), 32'd1);
        if (expect_result) begin
            if (vsub) begin
                e.diff = va - vb;
                e.br   = (va < vb);
            end else begin
                {e.br, e.diff} = {1'b0, va} + {1'b0, vb};
            end
            e.cyc = cyc + W;
            q.push_back(e);
        end
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_timeout", 32'(q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation, in the predicted cycle.
    always @(negedge clk) begin
        if (pend_ready) begin
            checkOutput("ready_after_done", 32'(ready), 32'd1);
            pend_ready = 1'b0;
        end
        if (rst_n && done) begin
            if (q.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                checkOutput("diff", 32'(diff), 32'(e.diff));
                checkOutput("borrow", 32'(borrow), 32'(e.br));
                checkOutput("done_cycle", 32'(cyc), 32'(e.cyc));
                checkOutput("ready_during_done", 32'(ready), 32'd0);
                pend_ready = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        pend_ready = 1'b0;
        rst_n      = 1'b0;
        start      = 1'b0;
        a          = '0;
        b          = '0;
        sub        = 1'b1;
        #12;
        checkOutput("rst_ready", 32'(ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_diff", 32'(diff), 32'd0);
        checkOutput("rst_borrow", 32'(borrow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, then a few random ones.
        applyStimulus(8'h05, 8'h03, 1'b1, 1'b1); waitIdle();
        applyStimulus(8'h03, 8'h05, 1'b1, 1'b1); waitIdle();
        applyStimulus(8'h00, 8'h00, 1'b1, 1'b1); waitIdle();
        applyStimulus(8'h80, 8'h01, 1'b1, 1'b1); waitIdle();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(W'($urandom), W'($urandom), 1'b1, 1'b1);
            waitIdle();
        end

        // A start pulsed mid-operation must be ignored entirely.
        applyStimulus(8'hA0, 8'h10, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        a     = 8'h01;
        b     = 8'h02;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitIdle();
        repeat (12) @(negedge clk);

        // Abort at E4: reset values at once and no done pulse afterwards.
        applyStimulus(8'hFF, 8'h01, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_ready", 32'(ready), 32'd1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_diff", 32'(diff), 32'd0);
        checkOutput("abort_borrow", 32'(borrow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("post_abort_diff", 32'(diff), 32'd0);

`ifdef SERIAL_SUB_ADD_MODE_EN
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b1); waitIdle();
        applyStimulus(8'h10, 8'h20, 1'b1, 1'b1); waitIdle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(W'($urandom), W'($urandom), 1'b0, 1'b1);
            waitIdle();
        end
`endif

        // Back-to-back requests with no idle gap between them.
        applyStimulus(8'h3C, 8'h0F, 1'b1, 1'b1);
        applyStimulus(8'h0F, 8'h3C, 1'b1, 1'b1);
        waitIdle();

        checkOutput("final_queue", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
